edge_mag: RTL

EDGE_MAG -- requirements
Module: edge_mag

---
 rtl/edge_mag.sv | 80 ++++++++
 1 files changed

// File: rtl/edge_mag.sv
// rtl/edge_mag.sv - Three-stage |gx|+|gy| edge magnitude with threshold and row/frame markers.
module edge_mag #(
    parameter int OUT_W = 3,
    parameter int OUT_H = 3,
    parameter int SHIFT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] gx_in,
    input  logic [15:0] gy_in,
    input  logic        valid_in,
    input  logic [7:0]  thresh,
    output logic [7:0]  mag_out,
    output logic        edge_out,
    output logic        valid_out,
    output logic        eol,
    output logic        eof
);

    localparam int CW = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int RW = (OUT_H > 1) ? $clog2(OUT_H) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(OUT_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(OUT_H - 1);

    logic [2:0]    vld;
    logic [16:0]   abs_x;
    logic [16:0]   abs_y;
    logic [17:0]   sum;
    logic [17:0]   shifted;
    logic [7:0]    sat;
    logic [CW-1:0] col;
    logic [RW-1:0] row;

    // 17-bit result so that |-32768| is representable without wrapping.
    function automatic logic [16:0] abs16(input logic [15:0] v);
        return v[15] ? (~{1'b1, v} + 17'd1) : {1'b0, v};
    endfunction

    assign shifted   = sum >> SHIFT;
    assign sat       = (shifted > 18'd255) ? 8'hFF : shifted[7:0];
    assign valid_out = vld[2];
    assign eol       = valid_out & (col == COL_LAST);
    assign eof       = eol & (row == ROW_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            vld      <= 3'b000;
            abs_x    <= '0;
            abs_y    <= '0;
            sum      <= '0;
            mag_out  <= '0;
            edge_out <= 1'b0;
        end else begin
            vld   <= {vld[1:0], valid_in};
            abs_x <= abs16(gx_in);
            abs_y <= abs16(gy_in);
            sum   <= {1'b0, abs_x} + {1'b0, abs_y};
            // Output registers hold their last value across bubbles.
            if (vld[1]) begin
                mag_out  <= sat;
                edge_out <= (sat > thresh);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col <= '0;
            row <= '0;
        end else if (valid_out) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

endmodule
